// File: rtl/key_expand.sv
`default_nettype none
// ============================================================================
//  Module      : key_expand_g
//  Description : AES key-schedule g word transform.
//                g(w) = SubWord(RotWord(w)) ^ {Rcon, 24'h0}
//                Rcon is chosen by round select and flag:
//                  sel 0 -> 01 (flag 0) or 02 (flag 1)
//                  sel 1..8 -> 04,08,10,20,40,80,1B,36
//  Ports       : word      - input word (w3 of the current key)
//                rnd_sel   - round select, 0..8
//                rcon_flag - picks 02 instead of 01 when rnd_sel == 0
//                g_out     - transformed word
//  Revision    : 1.0  initial release
// ============================================================================
module key_expand_g (
    input  logic [31:0] word,
    input  logic [3:0]  rnd_sel,
    input  logic        rcon_flag,
    output logic [31:0] g_out
);

    localparam logic [7:0] c_sbox [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [7:0] w_rcon;

    always_comb begin
        w_rcon = 8'h00;
        case (rnd_sel)
            4'd0:    w_rcon = rcon_flag ? 8'h02 : 8'h01;
            4'd1:    w_rcon = 8'h04;
            4'd2:    w_rcon = 8'h08;
            4'd3:    w_rcon = 8'h10;
            4'd4:    w_rcon = 8'h20;
            4'd5:    w_rcon = 8'h40;
            4'd6:    w_rcon = 8'h80;
            4'd7:    w_rcon = 8'h1b;
            4'd8:    w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // RotWord moves byte 0 to the end, then each byte goes through the S-box.
    assign g_out = {c_sbox[word[23:16]] ^ w_rcon,
                    c_sbox[word[15:8]],
                    c_sbox[word[7:0]],
                    c_sbox[word[31:24]]};

endmodule

// ============================================================================
//  Module      : key_expand
//  Description : AES-128 key-schedule sequencer. Accepts a cipher key and
//                streams round keys 0..10 over valid/ready, one per cycle
//                when not stalled. Optional 11-entry round-key store with a
//                registered random-access read port.
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                key_in/key_valid/key_ready - cipher key input handshake
//                rk_out/rk_idx/rk_valid/rk_ready/rk_last - round key stream
//                rd_idx/rd_key        - store read port (1-cycle latency)
//                store_valid          - all 11 keys present in the store
//  Revision    : 1.0  initial release
// ============================================================================
module key_expand #(
    parameter int STORE_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         rk_last,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
    output logic         store_valid
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t       r_state;
    logic         r_store_valid;

    logic         w_accept;
    logic         w_adv;
    logic [3:0]   w_rnd_sel;
    logic         w_rcon_flag;
    logic [31:0]  w_g;
    logic [127:0] w_next;
    logic [31:0]  w_w4, w_w5, w_w6, w_w7;
    logic         w_wr_en;
    logic [3:0]   w_wr_idx;
    logic [127:0] w_wr_data;

    assign w_accept = key_valid & key_ready;
    assign w_adv    = rk_valid & rk_ready;
    assign rk_last  = rk_valid & (rk_idx == 4'd10);

    // Key r = rk_idx+1 is being produced: r=1,2 share select 0 (flag picks
    // 01 vs 02); r>=3 uses select r-2, i.e. rk_idx-1.
    always_comb begin
        w_rcon_flag = (rk_idx == 4'd1);
        w_rnd_sel   = 4'd0;
        if (rk_idx >= 4'd2) begin
            w_rnd_sel = rk_idx - 4'd1;
        end
    end

    key_expand_g u_g (
        .word      (rk_out[31:0]),
        .rnd_sel   (w_rnd_sel),
        .rcon_flag (w_rcon_flag),
        .g_out     (w_g)
    );

    assign w_w4   = rk_out[127:96] ^ w_g;
    assign w_w5   = w_w4 ^ rk_out[95:64];
    assign w_w6   = w_w5 ^ rk_out[63:32];
    assign w_w7   = w_w6 ^ rk_out[31:0];
    assign w_next = {w_w4, w_w5, w_w6, w_w7};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            key_ready     <= 1'b1;
            rk_valid      <= 1'b0;
            rk_idx        <= 4'd0;
            rk_out        <= '0;
            r_store_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        rk_out        <= key_in;
                        rk_idx        <= 4'd0;
                        rk_valid      <= 1'b1;
                        key_ready     <= 1'b0;
                        r_store_valid <= 1'b0;
                        r_state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_adv) begin
                        if (rk_idx == 4'd10) begin
                            rk_valid      <= 1'b0;
                            key_ready     <= 1'b1;
                            r_store_valid <= 1'b1;
                            r_state       <= ST_IDLE;
                        end else begin
                            rk_out <= w_next;
                            rk_idx <= rk_idx + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Store write port mirrors the rk_out update: key 0 on accept, key r on
    // each non-final advance.
    assign w_wr_en   = w_accept | (w_adv & (rk_idx != 4'd10));
    assign w_wr_idx  = w_accept ? 4'd0 : (rk_idx + 4'd1);
    assign w_wr_data = w_accept ? key_in : w_next;

    generate
        if (STORE_EN != 0) begin : g_store
            logic [127:0] r_store [11];

            // Contents are intentionally not reset; store_valid qualifies them.
            always_ff @(posedge clk) begin
                if (w_wr_en && !rst) begin
                    r_store[w_wr_idx] <= w_wr_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_key <= '0;
                end else if (rd_idx <= 4'd10) begin
                    rd_key <= r_store[rd_idx];
                end else begin
                    rd_key <= '0;
                end
            end

            assign store_valid = r_store_valid;
        end else begin : g_no_store
            assign rd_key      = '0;
            assign store_valid = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_expand.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_expand
//  Description : Self-checking bench for key_expand. An independent model
//                (S-box derived from GF(2^8) inverse + affine map, Rcon by
//                repeated doubling) fills a scoreboard on every key accept;
//                handshakes pop and compare. Known FIPS-197 values are also
//                checked directly.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_expand;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         rk_last;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic         store_valid;

    int n_checks = 0;
    int n_errors = 0;
    bit rnd_mode = 1'b0;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
    } sb_item_t;

    sb_item_t     sb_q[$];
    logic [7:0]   sbt [256];

    logic         stall_pend = 1'b0;
    logic [127:0] prev_out;
    logic [3:0]   prev_idx;

    localparam logic [127:0] c_fips    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_fips_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_fips_2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] c_fips_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_zero_1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] c_zero_10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    always #5 clk = ~clk;

    key_expand #(.STORE_EN(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .rk_out      (rk_out),
        .rk_idx      (rk_idx),
        .rk_valid    (rk_valid),
        .rk_ready    (rk_ready),
        .rk_last     (rk_last),
        .rd_idx      (rd_idx),
        .rd_key      (rd_key),
        .store_valid (store_valid)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            sbt[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0 = k[127:96];
        logic [31:0] w1 = k[95:64];
        logic [31:0] w2 = k[63:32];
        logic [31:0] w3 = k[31:0];
        logic [31:0] t, w4, w5, w6, w7;
        t  = {sbt[w3[23:16]] ^ rc, sbt[w3[15:8]], sbt[w3[7:0]], sbt[w3[31:24]]};
        w4 = w0 ^ t;
        w5 = w4 ^ w1;
        w6 = w5 ^ w2;
        w7 = w6 ^ w3;
        return {w4, w5, w6, w7};
    endfunction

    task automatic push_expansion(input logic [127:0] key);
        logic [127:0] k  = key;
        logic [7:0]   rc = 8'h01;
        sb_item_t     it;
        for (int i = 0; i < 11; i++) begin
            it.idx = 4'(i);
            it.key = k;
            sb_q.push_back(it);
            k  = model_next(k, rc);
            rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
        end
    endtask

    // Monitor: mid-cycle sampling, inputs change #1 after posedge.
    always @(negedge clk) begin
        sb_item_t e;
        if (!rst && key_valid && key_ready) begin
            push_expansion(key_in);
        end
        if (stall_pend && !rst) begin
            check("stall_out", rk_out, prev_out);
            check("stall_idx", 128'(rk_idx), 128'(prev_idx));
            check("stall_valid", 128'(rk_valid), 128'd1);
        end
        stall_pend = !rst && rk_valid && !rk_ready;
        prev_out   = rk_out;
        prev_idx   = rk_idx;
        if (!rst && rk_valid && rk_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 128'(sb_q.size()), 128'd1);
            end else begin
                e = sb_q.pop_front();
                check("rk_idx", 128'(rk_idx), 128'(e.idx));
                check("rk_out", rk_out, e.key);
                check("rk_last", 128'(rk_last), 128'(e.idx == 4'd10));
            end
        end
        if (rst) sb_q.delete();
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rk_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (key_ready) break;
            tick();
        end
        check("idle_timeout", 128'(key_ready), 128'd1);
    endtask

    task automatic run_key(input logic [127:0] k, input logic [127:0] e1,
                           input logic [127:0] e10, input bit chk2, input logic [127:0] e2);
        key_in    = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            check("run_valid", 128'(rk_valid), 128'd1);
            if (i == 0) check("run_idx0", rk_out, k);
            if (i == 1) check("run_idx1", rk_out, e1);
            if (i == 2 && chk2) check("run_idx2", rk_out, e2);
            if (i == 10) begin
                check("run_idx10", rk_out, e10);
                check("run_last", 128'(rk_last), 128'd1);
            end
            tick();
        end
        check("end_valid", 128'(rk_valid), 128'd0);
        check("end_ready", 128'(key_ready), 128'd1);
        check("end_store_valid", 128'(store_valid), 128'd1);
    endtask

    initial begin
        rst       = 1'b1;
        key_in    = '0;
        key_valid = 1'b0;
        rk_ready  = 1'b1;
        rd_idx    = 4'd0;
        build_sbox();

        tick();
        tick();
        check("rst_key_ready", 128'(key_ready), 128'd1);
        check("rst_rk_valid", 128'(rk_valid), 128'd0);
        check("rst_rk_last", 128'(rk_last), 128'd0);
        check("rst_rk_idx", 128'(rk_idx), 128'd0);
        check("rst_rk_out", rk_out, 128'd0);
        check("rst_rd_key", rd_key, 128'd0);
        check("rst_store_valid", 128'(store_valid), 128'd0);
        rst = 1'b0;
        tick();

        // FIPS-197 key, full throughput
        run_key(c_fips, c_fips_1, c_fips_10, 1'b1, c_fips_2);

        // Store reads
        rd_idx = 4'd1;
        tick();
        check("rd_idx1", rd_key, c_fips_1);
        rd_idx = 4'd10;
        tick();
        check("rd_idx10", rd_key, c_fips_10);
        rd_idx = 4'd12;
        tick();
        check("rd_idx12", rd_key, 128'd0);
        rd_idx = 4'd0;
        tick();
        check("rd_idx0", rd_key, c_fips);

        // Same key with random backpressure
        rnd_mode  = 1'b1;
        key_in    = c_fips;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        check("rnd_first_idx", 128'(rk_idx), 128'd0);
        check("rnd_store_cleared", 128'(store_valid), 128'd0);
        wait_idle();
        check("rnd_sb_empty", 128'(sb_q.size()), 128'd0);
        rnd_mode = 1'b0;
        tick();

        // All-zero key
        run_key(128'd0, c_zero_1, c_zero_10, 1'b0, 128'd0);

        // Reset mid-operation at rk_idx == 5
        key_in    = c_fips;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rk_idx == 4'd5) break;
            tick();
        end
        check("mid_reached_idx5", 128'(rk_idx), 128'd5);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 128'(rk_valid), 128'd0);
        check("mid_rst_key_ready", 128'(key_ready), 128'd1);
        check("mid_rst_store_valid", 128'(store_valid), 128'd0);
        rst = 1'b0;
        tick();
        run_key(c_fips, c_fips_1, c_fips_10, 1'b1, c_fips_2);

        // key_valid held high through RUN with a different key
        key_in    = c_fips;
        key_valid = 1'b1;
        tick();
        key_in = 128'd0;
        check("hold_first", rk_out, c_fips);
        wait_idle();
        // key_ready just rose; the held key is taken on the next edge
        check("hold_not_yet", 128'(rk_valid), 128'd0);
        tick();
        key_valid = 1'b0;
        check("hold_accept_valid", 128'(rk_valid), 128'd1);
        check("hold_accept_idx", 128'(rk_idx), 128'd0);
        check("hold_accept_key", rk_out, 128'd0);
        check("hold_store_cleared", 128'(store_valid), 128'd0);
        wait_idle();
        tick();
        check("final_sb_empty", 128'(sb_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
